memory_ctrl: RTL and testbench

Parametrised successor of the SAP-3 byte memory: a memory address register (MAR) plus a RAM array, both loaded from the shared bus. Adds configurable width and depth, MAR auto-increment, and a two-cycle sequenced 16-bit (little-endian byte pair) read/write mode with a busy/done handshake. Sits on the CPU bus between the control unit (strobes) and the bus output mux (out).

---
 rtl/memory_ctrl.sv | 140 ++++++++++++++
 tb/tb_memory_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// Bus-loaded MAR plus RAM with byte access and a two-cycle sequenced little-endian word read/write.
// Byte reads are combinational; word ops take 2 cycles after the request edge and then pulse done. Requests made while busy are dropped.
module memory_ctrl #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 16,
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "../program.bin"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mar_we,
  input  logic                mar_inc,
  input  logic                ram_we,
  input  logic                rd_req,
  input  logic                word_mode,
  input  logic [2*DATA_W-1:0] bus,
  output logic [2*DATA_W-1:0] out,
  output logic [ADDR_W-1:0]   mar_out,
  output logic                busy,
  output logic                done
);

  localparam int BUS_W = 2 * DATA_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI} state_t;

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    logic [31:0] wide;
    wide = 32'(a);
    return IDX_W'(wide % 32'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  mar_q, mar_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic [BUS_W-1:0]   wbuf_q, wbuf_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   mar_idx;
  logic [IDX_W-1:0]   base_nxt;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  assign mar_idx  = idx(mar_q);
  assign base_nxt = (base_q == IDX_W'(DEPTH - 1)) ? '0 : base_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    rdata_d   = rdata_q;
    wbuf_d    = wbuf_q;
    base_d    = base_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = mar_idx;
    mem_wdata = bus[DATA_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (mar_we) begin
          mar_d = ADDR_W'(bus);
        end else if (mar_inc) begin
          mar_d = mar_q + (word_mode ? ADDR_W'(2) : ADDR_W'(1));
        end
        // Write beats read when both are requested in word mode.
        if (word_mode) begin
          if (ram_we) begin
            base_d  = mar_idx;
            wbuf_d  = bus;
            state_d = WR_LO;
          end else if (rd_req) begin
            base_d  = mar_idx;
            state_d = RD_LO;
          end
        end else if (ram_we) begin
          mem_we = 1'b1;
        end
      end
      WR_LO: begin
        mem_we    = 1'b1;
        mem_waddr = base_q;
        mem_wdata = wbuf_q[DATA_W-1:0];
        state_d   = WR_HI;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_waddr = base_nxt;
        mem_wdata = wbuf_q[BUS_W-1:DATA_W];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      RD_LO: begin
        rdata_d[DATA_W-1:0] = mem[base_q];
        state_d             = RD_HI;
      end
      RD_HI: begin
        rdata_d[BUS_W-1:DATA_W] = mem[base_nxt];
        done_d                  = 1'b1;
        state_d                 = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mar_q   <= '0;
      rdata_q <= '0;
      wbuf_q  <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      rdata_q <= rdata_d;
      wbuf_q  <= wbuf_d;
      base_q  <= base_d;
      done_q  <= done_d;
    end
  end

  // RAM is not reset; gating on rst keeps an aborted sequence from landing its pending byte.
  always @(posedge clk) begin
    if (mem_we && rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out     = word_mode ? rdata_q : BUS_W'(mem[mar_idx]);
  assign mar_out = mar_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed and randomized checks of memory_ctrl against a byte-array reference model.
module tb_memory_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        mar_we, mar_inc, ram_we, rd_req, word_mode;
  logic [15:0] bus;
  logic [15:0] out;
  logic [15:0] mar_out;
  logic        busy, done;

  always #5 clk = ~clk;

  memory_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .mar_we(mar_we), .mar_inc(mar_inc), .ram_we(ram_we),
    .rd_req(rd_req), .word_mode(word_mode), .bus(bus), .out(out),
    .mar_out(mar_out), .busy(busy), .done(done)
  );

  // Reference model: plain byte array, MAR value and last word read.
  logic [7:0]  mem_m [DEPTH];
  logic [15:0] mar_m;
  logic [15:0] rdata_m;
  int          total = 0;
  int          bad   = 0;

  function automatic int ix(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input logic [15:0] a);
    mar_we = 1'b1;
    bus    = a;
    tick();
    mar_we = 1'b0;
    bus    = '0;
    mar_m  = a;
  endtask

  task automatic check_byte(input logic [15:0] a, input string tag);
    set_mar(a);
    word_mode = 1'b0;
    #1;
    chk(tag, 32'(out), 32'(mem_m[ix(a)]));
  endtask

  task automatic byte_write(input logic [15:0] a, input logic [7:0] d);
    set_mar(a);
    word_mode = 1'b0;
    ram_we    = 1'b1;
    bus       = {8'h00, d};
    tick();
    ram_we    = 1'b0;
    bus       = '0;
    mem_m[ix(a)] = d;
    chk("byte_wr_out", 32'(out), 32'(d));
  endtask

  task automatic inc(input logic wm);
    word_mode = wm;
    mar_inc   = 1'b1;
    tick();
    mar_inc   = 1'b0;
    mar_m     = mar_m + (wm ? 16'd2 : 16'd1);
    chk("mar_inc", 32'(mar_out), 32'(mar_m));
  endtask

  // Ends in the cycle where done is high.
  task automatic word_write(input logic [15:0] d);
    int b;
    b = ix(mar_m);
    word_mode = 1'b1;
    ram_we    = 1'b1;
    bus       = d;
    tick();
    ram_we    = 1'b0;
    bus       = '0;
    chk("ww_busy_c1", 32'(busy), 32'd1);
    chk("ww_done_c1", 32'(done), 32'd0);
    tick();
    chk("ww_busy_c2", 32'(busy), 32'd1);
    tick();
    chk("ww_busy_end", 32'(busy), 32'd0);
    chk("ww_done", 32'(done), 32'd1);
    mem_m[b]             = d[7:0];
    mem_m[(b + 1) % DEPTH] = d[15:8];
  endtask

  task automatic word_read();
    int b;
    b = ix(mar_m);
    word_mode = 1'b1;
    rd_req    = 1'b1;
    tick();
    rd_req    = 1'b0;
    chk("wr_busy_c1", 32'(busy), 32'd1);
    tick();
    tick();
    chk("wr_done", 32'(done), 32'd1);
    rdata_m = {mem_m[(b + 1) % DEPTH], mem_m[b]};
    chk("wr_data", 32'(out), 32'(rdata_m));
  endtask

  initial begin
    logic [7:0]  v;
    logic [15:0] a, d, prev;
    int          op;

    rst = 1'b0; mar_we = 0; mar_inc = 0; ram_we = 0; rd_req = 0; word_mode = 0; bus = '0;
    mar_m = '0; rdata_m = '0;
    tick();
    tick();
    chk("rst_mar", 32'(mar_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    word_mode = 1'b1;
    #1;
    chk("rst_rdata", 32'(out), 32'd0);
    word_mode = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Fill RAM: byte write and MAR increment on the same edge.
    set_mar(16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      ram_we = 1'b1; mar_inc = 1'b1; bus = {8'h00, v};
      tick();
      mem_m[i] = v;
    end
    ram_we = 1'b0; mar_inc = 1'b0; bus = '0;
    mar_m = mar_m + 16'(DEPTH);
    chk("fill_mar", 32'(mar_out), 32'(mar_m));

    // Byte path.
    byte_write(16'h0042, 8'h5A);
    chk("byte_out_5a", 32'(out), 32'h005A);
    inc(1'b0);
    chk("byte_mar_43", 32'(mar_out), 32'h0043);

    // Word write then read back.
    set_mar(16'h0020);
    word_write(16'h1234);
    tick();
    chk("ww_done_pulse", 32'(done), 32'd0);
    check_byte(16'h0020, "ww_lo");
    check_byte(16'h0021, "ww_hi");
    chk("ww_model_lo", 32'(mem_m[8'h20]), 32'h34);
    set_mar(16'h0020);
    word_read();
    chk("wr_1234", 32'(out), 32'h1234);
    tick();
    chk("wr_hold", 32'(out), 32'h1234);
    chk("wr_done_pulse", 32'(done), 32'd0);

    // Location wrap and MAR wrap.
    set_mar(16'h00FF);
    word_write(16'hA55A);
    check_byte(16'h00FF, "wrap_lo");
    check_byte(16'h0000, "wrap_hi");
    set_mar(16'hFFFF);
    inc(1'b1);
    chk("mar_wrap", 32'(mar_out), 32'h0001);

    // Requests during a read are dropped.
    set_mar(16'h0060);
    word_mode = 1'b1;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    mar_we = 1'b1; ram_we = 1'b1; bus = 16'h0050;
    tick();
    mar_we = 1'b0; ram_we = 1'b0; bus = '0;
    chk("drop_mar", 32'(mar_out), 32'h0060);
    tick();
    chk("drop_done", 32'(done), 32'd1);
    rdata_m = {mem_m[8'h61], mem_m[8'h60]};
    chk("drop_rdata", 32'(out), 32'(rdata_m));
    tick();
    chk("drop_no_seq", 32'(busy), 32'd0);
    check_byte(16'h0060, "drop_m60");
    check_byte(16'h0050, "drop_m50");

    // Write wins over read; mar_we wins over mar_inc.
    prev = rdata_m;
    set_mar(16'h0070);
    word_mode = 1'b1;
    ram_we = 1'b1; rd_req = 1'b1; bus = 16'hCAFE;
    tick();
    ram_we = 1'b0; rd_req = 1'b0; bus = '0;
    tick();
    tick();
    chk("prio_done", 32'(done), 32'd1);
    chk("prio_rdata", 32'(out), 32'(prev));
    mem_m[8'h70] = 8'hFE;
    mem_m[8'h71] = 8'hCA;
    check_byte(16'h0070, "prio_lo");
    check_byte(16'h0071, "prio_hi");
    mar_we = 1'b1; mar_inc = 1'b1; bus = 16'h0030;
    tick();
    mar_we = 1'b0; mar_inc = 1'b0; bus = '0;
    mar_m = 16'h0030;
    chk("prio_mar", 32'(mar_out), 32'h0030);

    // Reset in WR_HI aborts the high byte.
    set_mar(16'h0010);
    word_mode = 1'b1;
    ram_we = 1'b1; bus = 16'hBEEF;
    tick();
    ram_we = 1'b0; bus = '0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_mar", 32'(mar_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_rdata", 32'(out), 32'd0);
    mem_m[8'h10] = 8'hEF;
    mar_m = '0;
    rdata_m = '0;
    @(negedge clk);
    rst = 1'b1;
    word_mode = 1'b0;
    #1;
    chk("arst_out_m0", 32'(out), 32'(mem_m[0]));
    tick();
    check_byte(16'h0010, "arst_m10");
    check_byte(16'h0011, "arst_m11");

    // Randomized mix; word ops hand straight over from their done cycle.
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 4));
      a  = 16'($urandom);
      d  = 16'($urandom);
      case (op)
        0: byte_write(a, d[7:0]);
        1: check_byte(a, "rnd_byte");
        2: begin set_mar(a); word_write(d); end
        3: begin set_mar(a); word_read(); end
        default: inc(d[0]);
      endcase
    end

    for (int i = 0; i < DEPTH; i++) begin
      check_byte(16'(i), "sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
